sel_fu_q: RTL and testbench
===========================

Name: sel_fu_q

Overview:
- Parametrised, buffered select functional unit: next generation of the select FU.
- Computes a move/select result at issue and queues it in a DEPTH-entry FIFO.
- Drains each entry to the CDB and the ROB under independent per-channel handshakes.
- Adds a conditional-select mode (cmov on a third dependency value) and decouples issue from writeback stalls.

Parameters:
DATA_W, 8, datapath width of operand, depvals, result
ROBID_W, 4, ROB tag width
FLAGS_W, 8, flags field width (min 4)
DEPTH, 4, result queue entries (power of two, >=2)

Ports:
clk  input  1  clock
rst  input  1  reset
input_transmit  input  1  issue valid
operand  input  DATA_W  immediate
depvals  input  3 x DATA_W  [0]=a, [1]=b, [2]=condition
wbs  input  8  writeback select, passed through
flags  input  FLAGS_W  [0]=wb_pc (no CDB write), [1]=b from operand, [2]=select b, [3]=conditional select
robid  input  ROBID_W  ROB tag
cdb_transmit  input  1  CDB grant
cdb_transmit_out  output  1  CDB request
cdb_id  output  ROBID_W  CDB tag
cdb_val  output  DATA_W  CDB value
rob_transmit  input  1  ROB grant
rob_transmit_out  output  1  ROB request
robid_out  output  ROBID_W  ROB tag
flags_out  output  FLAGS_W  flags
wbs_out  output  8  wbs
value_out  output  DATA_W  result
busy  output  1  queue full; issue stalled

Behaviour:
- Single clock clk; rst synchronous, active-high.
- Reset: queue empty, all outputs 0, busy 0.
- Operand b = flags[1] ? operand : depvals[1].
- Result:
  - flags[3]=1: result = (depvals[2] != 0) ? b : a. flags[2] ignored.
  - else: result = flags[2] ? b : a.
- Widths are DATA_W throughout; no extension.
- Enqueue when input_transmit && !busy. Stores result, robid, flags, wbs.
- Per-entry cdb_pend is set to !flags[0]; per-entry rob_pend is set to 1.
- input_transmit while busy: ignored, no entry written. Issuer must hold.
- busy = (count == DEPTH), registered from count.
- Full plus same-cycle retire: still no enqueue that cycle; busy drops the next cycle.
- Latency: issue in cycle N -> head outputs valid in cycle N+1 when the queue was empty.
- Head state machine, one per head entry:
  - EMPTY: all request outputs 0, data outputs 0.
  - BOTH: cdb_transmit_out=1 and rob_transmit_out=1.
  - CDB_ONLY: only the CDB request is pending.
  - ROB_ONLY: only the ROB request is pending.
- Entry state on arrival at head:
  - cdb_pend=1: BOTH.
  - cdb_pend=0 (wb_pc): ROB_ONLY. CDB is never requested.
- A channel completes in a cycle where its request and grant are both 1. Its request deasserts next cycle.
- The two channels complete independently and in either order. Both grants in the same cycle complete both.
- The entry retires when both channels are done. The next entry presents in the following cycle (one bubble per entry).
- Request outputs never drop without a grant. Data outputs stay stable while any request is held.
- A grant arriving while the matching request is 0 is ignored.
- cdb_id = robid_out = head robid. cdb_val = value_out = head result.
- Pointers wrap modulo DEPTH. count is updated by enqueue and retire in the same cycle.
- FIFO order is strict: entries retire in issue order.
- rst mid-operation: all entries dropped, outputs zero next cycle, no partial handshake retained.

Optional Feature:
SEL_FU_Q_FLUSH_EN:
- When defined: adds input port flush (1 bit).
- flush=1 empties the queue at the clock edge. All requests are 0 and busy 0 next cycle.
- Issue presented in the same cycle is discarded. Flush has priority over enqueue and grants.
- When undefined: no port; the queue drains only by handshake.

Test Plan:
- Reset, then issue a=0x11, b=0x22, flags=0x04, robid=3, both grants tied 1. Expect cycle+1: cdb_transmit_out=1, rob_transmit_out=1, cdb_val=0x22, cdb_id=3. Queue empty after 1 cycle.
- Issue flags=0x0A, operand=0x5A, depvals[2]=0 then 7, a=0x11. Expect value_out 0x11, then 0x5A.
- Issue flags=0x01, robid=9. Expect rob_transmit_out=1 with robid_out=9, cdb_transmit_out never 1. Retire on the rob grant alone.
- Hold grants at 0 and issue 4 entries. Expect busy=1, 5th issue dropped. Then assert cdb_transmit for 2 cycles before rob_transmit. Expect CDB request drops after the first grant, retire only on the ROB grant, busy=0 the next cycle, issue order preserved.
- With 2 entries queued and one half-complete, assert rst. Expect all outputs 0 next cycle and busy 0. A later issue is served normally.
- With SEL_FU_Q_FLUSH_EN, queue 3 entries and assert flush together with input_transmit. Expect empty queue, no requests, and the issued entry absent.

Source files
------------

// File: rtl/sel_fu_q.sv
// -----------------------------------------------------------------------------
// sel_fu_q -- buffered select functional unit
//
// Computes a move/select result at issue time and queues it, together with
// its ROB tag, flags and writeback select, in a DEPTH-entry FIFO. The head
// entry is drained to the CDB and to the ROB under two independent
// request/grant handshakes. The entry retires once both channels are done.
// Entries flagged wb_pc (flags[0]) never request the CDB.
//
// Result:
//   b      = flags[1] ? operand : depvals[1]
//   flags[3]=1 : result = (depvals[2] != 0) ? b : depvals[0]
//   flags[3]=0 : result = flags[2] ? b : depvals[0]
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               (only with SEL_FU_Q_FLUSH_EN) empty the queue
//   input_transmit      issue valid (ignored while busy)
//   operand             immediate
//   depvals[0..2]       a, b, condition
//   wbs                 writeback select, passed through
//   flags               [0]=wb_pc [1]=b from operand [2]=select b [3]=cmov
//   robid               ROB tag
//   cdb_transmit        CDB grant
//   cdb_transmit_out    CDB request
//   cdb_id, cdb_val     head tag / head result
//   rob_transmit        ROB grant
//   rob_transmit_out    ROB request
//   robid_out, flags_out, wbs_out, value_out   head entry fields
//   busy                queue full, issue stalled
//
// Optional feature macro: SEL_FU_Q_FLUSH_EN (adds the flush input).
// -----------------------------------------------------------------------------
module sel_fu_q #(
  parameter int DATA_W  = 8,
  parameter int ROBID_W = 4,
  parameter int FLAGS_W = 8,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef SEL_FU_Q_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic                   input_transmit,
  input  logic [DATA_W-1:0]      operand,
  input  logic [2:0][DATA_W-1:0] depvals,
  input  logic [7:0]             wbs,
  input  logic [FLAGS_W-1:0]     flags,
  input  logic [ROBID_W-1:0]     robid,
  input  logic                   cdb_transmit,
  output logic                   cdb_transmit_out,
  output logic [ROBID_W-1:0]     cdb_id,
  output logic [DATA_W-1:0]      cdb_val,
  input  logic                   rob_transmit,
  output logic                   rob_transmit_out,
  output logic [ROBID_W-1:0]     robid_out,
  output logic [FLAGS_W-1:0]     flags_out,
  output logic [7:0]             wbs_out,
  output logic [DATA_W-1:0]      value_out,
  output logic                   busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_BOTH,
    S_CDB_ONLY,
    S_ROB_ONLY
  } head_state_e;

  // Queue storage
  logic [DATA_W-1:0]  r_mem_val   [DEPTH];
  logic [ROBID_W-1:0] r_mem_robid [DEPTH];
  logic [FLAGS_W-1:0] r_mem_flags [DEPTH];
  logic [7:0]         r_mem_wbs   [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  head_state_e      r_state;

  logic [DATA_W-1:0] w_b;
  logic              w_sel_b;
  logic [DATA_W-1:0] w_result;
  logic              w_flush;
  logic              w_busy;
  logic              w_enq;
  logic              w_retire;
  logic              w_present;

`ifdef SEL_FU_Q_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Select datapath
  assign w_b      = flags[1] ? operand : depvals[1];
  assign w_sel_b  = flags[3] ? (depvals[2] != '0) : flags[2];
  assign w_result = w_sel_b ? w_b : depvals[0];

  // Full is judged on the registered count only, so a same-cycle retire
  // cannot open a slot for an issue in that cycle.
  assign w_busy = (r_count == CNT_W'(DEPTH));
  assign w_enq  = input_transmit && !w_busy && !w_flush;

  // Retire once the last outstanding channel is granted.
  always_comb begin
    w_retire = 1'b0;
    unique case (r_state)
      S_BOTH:     w_retire = cdb_transmit && rob_transmit;
      S_CDB_ONLY: w_retire = cdb_transmit;
      S_ROB_ONLY: w_retire = rob_transmit;
      default:    w_retire = 1'b0;
    endcase
  end

  // NOTE: storage carries no reset; the head FSM and count decide what is
  // visible, so stale payload never reaches an output and the array stays a
  // plain RAM-style register file.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem_val[r_wr_ptr]   <= w_result;
      r_mem_robid[r_wr_ptr] <= robid;
      r_mem_flags[r_wr_ptr] <= flags;
      r_mem_wbs[r_wr_ptr]   <= wbs;
    end
  end

  // NOTE: all state here is assigned with <= so every register samples the
  // pre-edge values; blocking assignments would let later statements see
  // already-updated pointers.
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= S_EMPTY;
    end else begin
      if (w_enq)    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_retire) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_retire);

      unique case (r_state)
        S_EMPTY: begin
          // A waiting entry presents after the retire bubble; an issue into an
          // empty queue presents directly in the next cycle.
          if (r_count != '0)
            r_state <= r_mem_flags[r_rd_ptr][0] ? S_ROB_ONLY : S_BOTH;
          else if (w_enq)
            r_state <= flags[0] ? S_ROB_ONLY : S_BOTH;
        end
        S_BOTH: begin
          if (cdb_transmit && rob_transmit) r_state <= S_EMPTY;
          else if (cdb_transmit)            r_state <= S_ROB_ONLY;
          else if (rob_transmit)            r_state <= S_CDB_ONLY;
        end
        S_CDB_ONLY: if (cdb_transmit) r_state <= S_EMPTY;
        S_ROB_ONLY: if (rob_transmit) r_state <= S_EMPTY;
        default:    r_state <= S_EMPTY;
      endcase
    end
  end

  // Outputs: requests follow the head state; data is zero when nothing is
  // presented and otherwise the stored head entry, stable until retire.
  assign w_present        = (r_state != S_EMPTY);
  assign cdb_transmit_out = (r_state == S_BOTH) || (r_state == S_CDB_ONLY);
  assign rob_transmit_out = (r_state == S_BOTH) || (r_state == S_ROB_ONLY);
  assign value_out        = w_present ? r_mem_val[r_rd_ptr]   : '0;
  assign robid_out        = w_present ? r_mem_robid[r_rd_ptr] : '0;
  assign flags_out        = w_present ? r_mem_flags[r_rd_ptr] : '0;
  assign wbs_out          = w_present ? r_mem_wbs[r_rd_ptr]   : '0;
  assign cdb_val          = value_out;
  assign cdb_id           = robid_out;
  assign busy             = w_busy;

endmodule

// File: tb/tb_sel_fu_q.sv
// -----------------------------------------------------------------------------
// tb_sel_fu_q -- self-checking bench for sel_fu_q.
// A queue-level reference model predicts every output each cycle; a few
// directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_sel_fu_q;
  localparam int DATA_W  = 8;
  localparam int ROBID_W = 4;
  localparam int FLAGS_W = 8;
  localparam int DEPTH   = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic                   input_transmit;
  logic [DATA_W-1:0]      operand;
  logic [2:0][DATA_W-1:0] depvals;
  logic [7:0]             wbs;
  logic [FLAGS_W-1:0]     flags;
  logic [ROBID_W-1:0]     robid;
  logic                   cdb_transmit;
  logic                   cdb_transmit_out;
  logic [ROBID_W-1:0]     cdb_id;
  logic [DATA_W-1:0]      cdb_val;
  logic                   rob_transmit;
  logic                   rob_transmit_out;
  logic [ROBID_W-1:0]     robid_out;
  logic [FLAGS_W-1:0]     flags_out;
  logic [7:0]             wbs_out;
  logic [DATA_W-1:0]      value_out;
  logic                   busy;

  int total = 0;
  int bad   = 0;

  sel_fu_q #(.DATA_W(DATA_W), .ROBID_W(ROBID_W), .FLAGS_W(FLAGS_W), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
`ifdef SEL_FU_Q_FLUSH_EN
    .flush            (flush),
`endif
    .input_transmit   (input_transmit),
    .operand          (operand),
    .depvals          (depvals),
    .wbs              (wbs),
    .flags            (flags),
    .robid            (robid),
    .cdb_transmit     (cdb_transmit),
    .cdb_transmit_out (cdb_transmit_out),
    .cdb_id           (cdb_id),
    .cdb_val          (cdb_val),
    .rob_transmit     (rob_transmit),
    .rob_transmit_out (rob_transmit_out),
    .robid_out        (robid_out),
    .flags_out        (flags_out),
    .wbs_out          (wbs_out),
    .value_out        (value_out),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [DATA_W-1:0]  val;
    logic [ROBID_W-1:0] id;
    logic [FLAGS_W-1:0] fl;
    logic [7:0]         wb;
  } ent_t;

  ent_t mq[$];
  bit   m_pres    = 0;   // head entry is being presented
  bit   m_cdb     = 0;   // CDB still owed for the presented head
  bit   m_rob     = 0;   // ROB still owed for the presented head
  bit   m_started = 0;

  function automatic logic [DATA_W-1:0] ref_result(
      input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b_dep,
      input logic [DATA_W-1:0] cond, input logic [DATA_W-1:0] imm,
      input logic [FLAGS_W-1:0] fl);
    logic [DATA_W-1:0] b;
    bit take_b;
    b = fl[1] ? imm : b_dep;
    if (fl[3]) take_b = (cond != 0);
    else       take_b = fl[2];
    return take_b ? b : a;
  endfunction

  always @(posedge clk) begin
    bit   was_pres;
    bit   full;
    ent_t e;
    if (rst || flush) begin
      mq.delete();
      m_pres = 0; m_cdb = 0; m_rob = 0;
      if (rst) m_started = 1;
    end else if (m_started) begin
      full     = (mq.size() == DEPTH);
      was_pres = m_pres;
      if (m_pres) begin
        if (cdb_transmit) m_cdb = 0;
        if (rob_transmit) m_rob = 0;
        if (!m_cdb && !m_rob) begin
          void'(mq.pop_front());
          m_pres = 0;
        end
      end
      if (input_transmit && !full) begin
        e.val = ref_result(depvals[0], depvals[1], depvals[2], operand, flags);
        e.id  = robid;
        e.fl  = flags;
        e.wb  = wbs;
        mq.push_back(e);
      end
      if (!was_pres && mq.size() > 0) begin
        m_pres = 1;
        m_cdb  = !mq[0].fl[0];
        m_rob  = 1;
      end
    end
  end

  // Single compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_started) begin
      check("busy",     busy,             mq.size() == DEPTH);
      check("cdb_req",  cdb_transmit_out, m_pres && m_cdb);
      check("rob_req",  rob_transmit_out, m_pres && m_rob);
      check("value",    value_out,        m_pres ? mq[0].val : '0);
      check("cdb_val",  cdb_val,          m_pres ? mq[0].val : '0);
      check("robid",    robid_out,        m_pres ? mq[0].id  : '0);
      check("cdb_id",   cdb_id,           m_pres ? mq[0].id  : '0);
      check("flags",    flags_out,        m_pres ? mq[0].fl  : '0);
      check("wbs",      wbs_out,          m_pres ? mq[0].wb  : '0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] imm, input logic [7:0] fl,
                       input logic [3:0] id, input logic [7:0] w);
    depvals[0] = a; depvals[1] = b; depvals[2] = c;
    operand = imm; flags = fl; robid = id; wbs = w;
    input_transmit = 1'b1;
    @(posedge clk); #1;
    input_transmit = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; input_transmit = 1'b0;
    operand = '0; depvals = '0; wbs = '0; flags = '0; robid = '0;
    cdb_transmit = 1'b0; rob_transmit = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("lit_rst_busy", busy, 0);
    check("lit_rst_cdb",  cdb_transmit_out, 0);
    check("lit_rst_rob",  rob_transmit_out, 0);
    check("lit_rst_val",  value_out, 0);

    // Plain select b, both grants tied high
    cdb_transmit = 1'b1; rob_transmit = 1'b1;
    issue(8'h11, 8'h22, 8'h00, 8'h00, 8'h04, 4'd3, 8'h33);
    @(negedge clk);
    check("lit_t1_cdbreq", cdb_transmit_out, 1);
    check("lit_t1_robreq", rob_transmit_out, 1);
    check("lit_t1_val",    cdb_val, 8'h22);
    check("lit_t1_id",     cdb_id, 3);
    check("lit_t1_wbs",    wbs_out, 8'h33);
    @(negedge clk);
    check("lit_t1_empty",  cdb_transmit_out | rob_transmit_out, 0);

    // Conditional select with immediate b
    issue(8'h11, 8'h99, 8'h00, 8'h5A, 8'h0A, 4'd1, 8'h00);
    @(negedge clk);
    check("lit_cmov_false", value_out, 8'h11);
    @(negedge clk);
    issue(8'h11, 8'h99, 8'h07, 8'h5A, 8'h0A, 4'd2, 8'h00);
    @(negedge clk);
    check("lit_cmov_true",  value_out, 8'h5A);
    @(negedge clk);

    // wb_pc entry: ROB only
    cdb_transmit = 1'b0; rob_transmit = 1'b0;
    issue(8'h01, 8'h02, 8'h00, 8'h00, 8'h01, 4'd9, 8'h00);
    @(negedge clk);
    check("lit_pc_robreq", rob_transmit_out, 1);
    check("lit_pc_robid",  robid_out, 9);
    check("lit_pc_cdbreq", cdb_transmit_out, 0);
    rob_transmit = 1'b1;
    @(posedge clk); #1 rob_transmit = 1'b0;
    @(negedge clk);
    check("lit_pc_retired", rob_transmit_out, 0);

    // Fill, drop, then split-order completion
    for (int i = 1; i <= 4; i++)
      issue(8'(i * 16), 8'(i * 16 + 1), 8'h00, 8'h00, 8'h04, 4'(i), 8'(i));
    @(negedge clk);
    check("lit_full_busy", busy, 1);
    check("lit_full_head", robid_out, 1);
    issue(8'hEE, 8'hEF, 8'h00, 8'h00, 8'h04, 4'd5, 8'h05);
    @(negedge clk);
    check("lit_drop_busy", busy, 1);
    cdb_transmit = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("lit_split_cdb", cdb_transmit_out, 0);
    check("lit_split_rob", rob_transmit_out, 1);
    check("lit_split_val", value_out, 8'h11);
    @(posedge clk); #1;
    cdb_transmit = 1'b0; rob_transmit = 1'b1;
    @(posedge clk); #1 rob_transmit = 1'b0;
    @(negedge clk);
    check("lit_split_busy", busy, 0);
    check("lit_bubble",     rob_transmit_out, 0);
    @(negedge clk);
    check("lit_next_head",  robid_out, 2);
    cdb_transmit = 1'b1; rob_transmit = 1'b1;
    repeat (12) @(posedge clk);
    #1;

    // Reset mid-operation with a half-complete head
    cdb_transmit = 1'b0; rob_transmit = 1'b0;
    issue(8'h61, 8'h62, 8'h00, 8'h00, 8'h04, 4'd6, 8'h06);
    issue(8'h71, 8'h72, 8'h00, 8'h00, 8'h04, 4'd7, 8'h07);
    cdb_transmit = 1'b1;
    @(posedge clk); #1 cdb_transmit = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("lit_mrst_busy", busy, 0);
    check("lit_mrst_req",  cdb_transmit_out | rob_transmit_out, 0);
    check("lit_mrst_val",  value_out, 0);
    cdb_transmit = 1'b1; rob_transmit = 1'b1;
    issue(8'h0C, 8'h3C, 8'h00, 8'h00, 8'h04, 4'hC, 8'h00);
    @(negedge clk);
    check("lit_after_rst_id",  cdb_id, 4'hC);
    check("lit_after_rst_val", cdb_val, 8'h3C);
    @(posedge clk); #1;

`ifdef SEL_FU_Q_FLUSH_EN
    cdb_transmit = 1'b0; rob_transmit = 1'b0;
    for (int i = 0; i < 3; i++)
      issue(8'(i), 8'(i + 8), 8'h00, 8'h00, 8'h04, 4'(i), 8'h00);
    flush = 1'b1;
    issue(8'hAA, 8'hBB, 8'h00, 8'h00, 8'h04, 4'hF, 8'h00);
    flush = 1'b0;
    @(negedge clk);
    check("lit_flush_req",  cdb_transmit_out | rob_transmit_out, 0);
    check("lit_flush_busy", busy, 0);
    @(negedge clk);
    check("lit_flush_absent", rob_transmit_out, 0);
    @(posedge clk); #1;
`endif

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      input_transmit = ($urandom_range(0, 99) < 60);
      depvals[0] = 8'($urandom);
      depvals[1] = 8'($urandom);
      depvals[2] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      operand    = 8'($urandom);
      flags      = 8'($urandom);
      robid      = 4'($urandom);
      wbs        = 8'($urandom);
      cdb_transmit = ($urandom_range(0, 99) < 45);
      rob_transmit = ($urandom_range(0, 99) < 45);
      rst          = ($urandom_range(0, 299) == 0);
`ifdef SEL_FU_Q_FLUSH_EN
      flush        = ($urandom_range(0, 199) == 0);
`endif
      @(posedge clk); #1;
    end
    rst = 1'b0; flush = 1'b0; input_transmit = 1'b0;
    cdb_transmit = 1'b1; rob_transmit = 1'b1;
    repeat (16) @(posedge clk);
    @(negedge clk);
    check("lit_final_drained", busy | cdb_transmit_out | rob_transmit_out, 0);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
